// File: rtl/irq_pkg.sv
// Shared encodings and defaults for the interrupt controller.
package irq_pkg;

  localparam int unsigned DEFAULT_IRQ_BITS    = 3;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  localparam logic [1:0] CFG_SEL_MASK = 2'd0;
  localparam logic [1:0] CFG_SEL_EDGE = 2'd1;
  localparam logic [1:0] CFG_SEL_PEND = 2'd2;
  localparam logic [1:0] CFG_SEL_INSV = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_controller_encoder.sv
// Priority encoder: index of the highest set input bit, 0 when no bit is set.
module Encoder #(
  parameter int unsigned OUT_WIDTH = 3
) (
  input  logic [(1<<OUT_WIDTH)-1:0] in_bits,
  output logic [OUT_WIDTH-1:0]      out_idx
);

  localparam int unsigned N = 1 << OUT_WIDTH;

  always_comb begin
    out_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_bits[i]) out_idx = OUT_WIDTH'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronise, latch, mask, nest, and hand one vector to the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned IRQ_BITS    = DEFAULT_IRQ_BITS,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [(1<<IRQ_BITS)-1:0]   irq_in,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [(1<<IRQ_BITS)-1:0]   cfg_wdata,
  output logic [(1<<IRQ_BITS)-1:0]   cfg_rdata,
  output logic                       irq_req,
  output logic [IRQ_BITS-1:0]        irq_vec,
  input  logic                       irq_ack,
  input  logic                       eoi
);

  localparam int unsigned N = 1 << IRQ_BITS;

  irq_state_t          state;
  logic [N-1:0]        synced;
  logic [N-1:0]        synced_d;
  logic [N-1:0]        rise;
  logic [N-1:0]        mask;
  logic [N-1:0]        edge_mode;
  logic [N-1:0]        pending;
  logic [N-1:0]        in_service;
  logic [N-1:0]        active;
  logic [N-1:0]        pending_nxt;
  logic [N-1:0]        insv_nxt;
  logic [N-1:0]        ack_clr;
  logic [IRQ_BITS-1:0] cand;
  logic [IRQ_BITS-1:0] is_top;
  logic                cand_valid;
  logic                is_valid;
  logic                eligible;
  logic                ack_hit;
  logic                vec_live;

  for (genvar g = 0; g < N; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], irq_in[g]};
    end
    assign synced[g] = chain[SYNC_STAGES-1];
  end

  assign rise   = synced & ~synced_d;
  assign active = pending & ~mask;

  Encoder #(.OUT_WIDTH(IRQ_BITS)) u_cand_enc (
    .in_bits (active),
    .out_idx (cand)
  );

  Encoder #(.OUT_WIDTH(IRQ_BITS)) u_insv_enc (
    .in_bits (in_service),
    .out_idx (is_top)
  );

  assign cand_valid = |active;
  assign is_valid   = |in_service;
  assign eligible   = cand_valid && (!is_valid || (cand > is_top));
  assign ack_hit    = (state == REQ) && irq_ack;
  assign vec_live   = active[irq_vec];

  // A rising edge arriving with the ack re-sets the bit the ack clears.
  always_comb begin
    ack_clr     = ack_hit ? ((N'(1) << irq_vec) & edge_mode) : '0;
    pending_nxt = (edge_mode & ((pending & ~ack_clr) | rise)) | (~edge_mode & synced);
    insv_nxt    = in_service;
    if (eoi && is_valid) insv_nxt[is_top]  = 1'b0;
    if (ack_hit)         insv_nxt[irq_vec] = 1'b1;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      CFG_SEL_MASK: cfg_rdata = mask;
      CFG_SEL_EDGE: cfg_rdata = edge_mode;
      CFG_SEL_PEND: cfg_rdata = pending;
      CFG_SEL_INSV: cfg_rdata = in_service;
      default:      cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced_d   <= '0;
      mask       <= '1;
      edge_mode  <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      synced_d   <= synced;
      pending    <= pending_nxt;
      in_service <= insv_nxt;
      if (cfg_we && (cfg_sel == CFG_SEL_MASK)) mask      <= cfg_wdata;
      if (cfg_we && (cfg_sel == CFG_SEL_EDGE)) edge_mode <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_vec <= cand;
          end
        end
        REQ: begin
          if (irq_ack || !vec_live) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level reference model and per-cycle compare.
module tb_irq_controller;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] irq_in = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic       irq_ack = 1'b0;
  logic       eoi = 1'b0;

  int total = 0;
  int bad   = 0;

  irq_controller #(.IRQ_BITS(3), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .eoi       (eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: line samples delayed through the synchroniser, then the rules applied.
  logic [7:0] md [0:S];
  logic [7:0] m_mask, m_edge, m_pend, m_is;
  logic       m_req;
  int         m_vec;
  logic [7:0] lvl, rs, act, np, nis;
  logic       ak;
  int         cnd;

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) md[k] = '0;
      m_mask = 8'hFF; m_edge = '0; m_pend = '0; m_is = '0; m_req = 1'b0; m_vec = 0;
    end else begin
      lvl = md[S-1];
      rs  = md[S-1] & ~md[S];
      act = m_pend & ~m_mask;
      cnd = top_bit(act);
      ak  = m_req && irq_ack;
      nis = m_is;
      if (eoi && m_is != 0) nis[top_bit(m_is)] = 1'b0;
      if (ak) nis[m_vec] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (m_edge[i]) np[i] = rs[i] | (m_pend[i] & ~(ak && m_vec == i));
        else           np[i] = lvl[i];
      end
      if (!m_req) begin
        if (cnd >= 0 && cnd > top_bit(m_is)) begin
          m_req = 1'b1;
          m_vec = cnd;
        end
      end else if (ak || !act[m_vec]) begin
        m_req = 1'b0;
      end
      for (int k = S; k > 0; k--) md[k] = md[k-1];
      md[0] = irq_in;
      if (cfg_we && cfg_sel == 2'd0) m_mask = cfg_wdata;
      if (cfg_we && cfg_sel == 2'd1) m_edge = cfg_wdata;
      m_pend = np;
      m_is   = nis;
    end
  end

  function automatic logic [7:0] m_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_mask;
      2'd1:    return m_edge;
      2'd2:    return m_pend;
      default: return m_is;
    endcase
  endfunction

  always @(negedge clk) begin
    if ($time > 2) begin
      chk("model_req", {31'd0, irq_req}, {31'd0, m_req});
      if (m_req) chk("model_vec", {29'd0, irq_vec}, m_vec);
      chk("model_rdata", {24'd0, cfg_rdata}, {24'd0, m_rdata(cfg_sel)});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] sel, input logic [7:0] exp);
    cfg_sel = sel;
    #1;
    chk(nm, {24'd0, cfg_rdata}, {24'd0, exp});
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq_in = lines;
    step();
    irq_in = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic [2:0] vec);
    int n = 0;
    while (!irq_req && n < 20) begin step(); n++; end
    chk({nm, "_req"}, {31'd0, irq_req}, 32'd1);
    chk({nm, "_vec"}, {29'd0, irq_vec}, {29'd0, vec});
  endtask

  task automatic wait_low(input string nm);
    int n = 0;
    while (irq_req && n < 20) begin step(); n++; end
    chk(nm, {31'd0, irq_req}, 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk_reg("rst_mask", 2'd0, 8'hFF);
    chk_reg("rst_edge", 2'd1, 8'h00);
    step();
    chk("rst_req", {31'd0, irq_req}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single edge on line 5, exact latency
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'hFF);
    pulse(8'h20);
    step(2);
    chk("t1_early", {31'd0, irq_req}, 32'd0);
    step();
    chk("t1_req", {31'd0, irq_req}, 32'd1);
    chk("t1_vec", {29'd0, irq_vec}, 32'd5);
    do_ack();
    chk_reg("t1_pend", 2'd2, 8'h00);
    chk_reg("t1_insv", 2'd3, 8'h20);
    do_eoi();
    chk_reg("t1_eoi", 2'd3, 8'h00);

    // 2: lines 2 and 6 together
    pulse(8'h44);
    wait_req("t2_first", 3'd6);
    do_ack();
    step(3);
    chk("t2_blocked", {31'd0, irq_req}, 32'd0);
    do_eoi();
    wait_req("t2_second", 3'd2);
    do_ack();
    do_eoi();

    // 3: nesting under line 6
    pulse(8'h40);
    wait_req("t3_six", 3'd6);
    do_ack();
    pulse(8'h08);
    step(5);
    chk("t3_lower_held", {31'd0, irq_req}, 32'd0);
    pulse(8'h80);
    wait_req("t3_nest", 3'd7);
    do_ack();
    chk_reg("t3_insv", 2'd3, 8'hC0);
    do_eoi();
    step(3);
    chk("t3_still_held", {31'd0, irq_req}, 32'd0);
    do_eoi();
    wait_req("t3_three", 3'd3);
    do_ack();
    do_eoi();

    // 4: level line 4 withdrawn by dropping the pin
    cfg_write(2'd1, 8'hEF);
    irq_in[4] = 1'b1;
    wait_req("t4_lvl", 3'd4);
    irq_in[4] = 1'b0;
    wait_low("t4_drop");
    step(2);
    chk("t4_idle", {31'd0, irq_req}, 32'd0);
    chk_reg("t4_insv", 2'd3, 8'h00);
    cfg_write(2'd1, 8'hFF);

    // 5: mask withdraw, then mask write racing an ack
    pulse(8'h02);
    wait_req("t5_one", 3'd1);
    cfg_write(2'd0, 8'h02);
    chk("t5_hold", {31'd0, irq_req}, 32'd1);
    step();
    chk("t5_withdrawn", {31'd0, irq_req}, 32'd0);
    cfg_write(2'd0, 8'h00);
    wait_req("t5_again", 3'd1);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_wdata = 8'h02; irq_ack = 1'b1;
    step();
    cfg_we = 1'b0; irq_ack = 1'b0;
    chk("t5_ack_req", {31'd0, irq_req}, 32'd0);
    chk_reg("t5_insv", 2'd3, 8'h02);
    cfg_write(2'd0, 8'h00);
    do_eoi();
    chk_reg("t5_clear", 2'd3, 8'h00);

    // 6: eoi + ack in one cycle, then reset mid-request
    pulse(8'h10);
    wait_req("t6_four", 3'd4);
    do_ack();
    pulse(8'h40);
    wait_req("t6_six", 3'd6);
    irq_ack = 1'b1; eoi = 1'b1;
    step();
    irq_ack = 1'b0; eoi = 1'b0;
    chk_reg("t6_insv", 2'd3, 8'h40);
    do_eoi();
    pulse(8'h20);
    wait_req("t6_five", 3'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, irq_req}, 32'd0);
    chk("t6_rst_vec", {29'd0, irq_vec}, 32'd0);
    step();
    chk_reg("t6_rst_mask", 2'd0, 8'hFF);
    chk_reg("t6_rst_edge", 2'd1, 8'h00);
    step();
    chk_reg("t6_rst_pend", 2'd2, 8'h00);
    chk_reg("t6_rst_insv", 2'd3, 8'h00);
    rst_n = 1'b1;
    step(6);
    chk("t6_post", {31'd0, irq_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
